// File: rtl/hazard_stall_unit.sv
// Pipeline stall/flush controller: load-use, multi-cycle mult/div occupancy and taken-branch squash.
// Optional HAZARD_PERF_EN adds saturating stall_count / flush_count performance counters.
module hazard_stall_unit #(
   parameter int MD_LATENCY = 4,
   parameter int CNT_W      = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] rs_num_ID,
   input  logic [4:0] rt_num_ID,
   input  logic       uses_rs_ID,
   input  logic       uses_rt_ID,
   input  logic       mem_read_EX,
   input  logic [4:0] rt_num_EX,
   input  logic       md_start_EX,
   input  logic       branch_taken_EX,
   output logic       stall_IF,
   output logic       stall_ID,
   output logic       stall_EX,
   output logic       flush_ID,
   output logic       flush_EX,
   output logic       flush_MEM,
   output logic       md_busy
`ifdef HAZARD_PERF_EN
   ,
   output logic [31:0] stall_count,
   output logic [31:0] flush_count
`endif
);

   typedef enum logic {RUN, MD_WAIT} state_t;

   state_t           state, state_n;
   logic [CNT_W-1:0] md_cnt, md_cnt_n;
   logic             md_hit;
   logic             load_use;

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= RUN;
         md_cnt <= '0;
      end else begin
         state  <= state_n;
         md_cnt <= md_cnt_n;
      end
   end

   // md_start_EX stays high on the release cycle (same instruction), so RUN is only re-entered then.
   assign md_hit = ((state == RUN) && md_start_EX) || ((state == MD_WAIT) && (md_cnt != '0));

   assign load_use = mem_read_EX && (rt_num_EX != 5'd0) &&
                     ((uses_rs_ID && (rs_num_ID == rt_num_EX)) ||
                      (uses_rt_ID && (rt_num_ID == rt_num_EX)));

   always_comb begin
      state_n  = state;
      md_cnt_n = md_cnt;
      case (state)
         RUN: begin
            if (md_start_EX) begin
               state_n  = MD_WAIT;
               md_cnt_n = CNT_W'(MD_LATENCY - 2);
            end
         end
         MD_WAIT: begin
            if (md_cnt != '0) md_cnt_n = md_cnt - CNT_W'(1);
            else              state_n  = RUN;
         end
         default: begin
            state_n  = RUN;
            md_cnt_n = '0;
         end
      endcase
   end

   always_comb begin
      stall_IF  = 1'b0;
      stall_ID  = 1'b0;
      stall_EX  = 1'b0;
      flush_ID  = 1'b0;
      flush_EX  = 1'b0;
      flush_MEM = 1'b0;
      md_busy   = 1'b0;
      if (!rst) begin
         if (md_hit) begin
            stall_IF  = 1'b1;
            stall_ID  = 1'b1;
            stall_EX  = 1'b1;
            flush_MEM = 1'b1;
            md_busy   = 1'b1;
         end else if (branch_taken_EX) begin
            flush_ID = 1'b1;
            flush_EX = 1'b1;
         end else if (load_use) begin
            stall_IF = 1'b1;
            stall_ID = 1'b1;
            flush_EX = 1'b1;
         end
      end
   end

`ifdef HAZARD_PERF_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_count <= '0;
         flush_count <= '0;
      end else begin
         if (stall_IF && (stall_count != '1)) stall_count <= stall_count + 32'd1;
         if (flush_ID && (flush_count != '1)) flush_count <= flush_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Self-checking bench for hazard_stall_unit: directed scenarios then randomized traffic vs. a cycle-count model.
// Counter checks are compiled in when HAZARD_PERF_EN is defined.
module tb_hazard_stall_unit;

   localparam int L = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] rs_num_ID, rt_num_ID, rt_num_EX;
   logic       uses_rs_ID, uses_rt_ID, mem_read_EX, md_start_EX, branch_taken_EX;
   logic       stall_IF, stall_ID, stall_EX, flush_ID, flush_EX, flush_MEM, md_busy;
`ifdef HAZARD_PERF_EN
   logic [31:0] stall_count, flush_count;
   longint      m_stalls, m_flushes;
`endif

   int passed = 0;
   int total  = 0;

   // Model: remaining mult/div stall cycles, and whether this cycle is the release cycle.
   int m_left    = 0;
   bit m_release = 1'b0;

   always #5 clk = ~clk;

   hazard_stall_unit #(.MD_LATENCY(L), .CNT_W(4)) dut (
      .clk(clk), .rst(rst),
      .rs_num_ID(rs_num_ID), .rt_num_ID(rt_num_ID),
      .uses_rs_ID(uses_rs_ID), .uses_rt_ID(uses_rt_ID),
      .mem_read_EX(mem_read_EX), .rt_num_EX(rt_num_EX),
      .md_start_EX(md_start_EX), .branch_taken_EX(branch_taken_EX),
      .stall_IF(stall_IF), .stall_ID(stall_ID), .stall_EX(stall_EX),
      .flush_ID(flush_ID), .flush_EX(flush_EX), .flush_MEM(flush_MEM),
      .md_busy(md_busy)
`ifdef HAZARD_PERF_EN
      , .stall_count(stall_count), .flush_count(flush_count)
`endif
   );

   // Order: {stall_IF, stall_ID, stall_EX, flush_ID, flush_EX, flush_MEM, md_busy}
   function automatic logic [6:0] model_out();
      bit lu;
      if (rst) return 7'b0;
      if (m_left > 0 || (!m_release && md_start_EX)) return 7'b1110011;
      if (branch_taken_EX) return 7'b0001100;
      lu = mem_read_EX && (rt_num_EX != 0) &&
           ((uses_rs_ID && rs_num_ID == rt_num_EX) || (uses_rt_ID && rt_num_ID == rt_num_EX));
      if (lu) return 7'b1100100;
      return 7'b0;
   endfunction

   task automatic model_step(input logic [6:0] o);
      if (rst) begin
         m_left = 0;
         m_release = 1'b0;
      end else if (m_left > 0) begin
         m_left--;
         if (m_left == 0) m_release = 1'b1;
      end else if (m_release) begin
         m_release = 1'b0;
      end else if (md_start_EX) begin
         m_left = L - 2;
         if (m_left == 0) m_release = 1'b1;
      end
`ifdef HAZARD_PERF_EN
      if (rst) begin
         m_stalls = 0;
         m_flushes = 0;
      end else begin
         if (o[6] && m_stalls  < 64'hFFFF_FFFF) m_stalls++;
         if (o[3] && m_flushes < 64'hFFFF_FFFF) m_flushes++;
      end
`else
      if (o === 7'bx) m_left = m_left;
`endif
   endtask

   task automatic idle();
      rs_num_ID = 5'd0; rt_num_ID = 5'd0; rt_num_EX = 5'd0;
      uses_rs_ID = 1'b0; uses_rt_ID = 1'b0; mem_read_EX = 1'b0;
      md_start_EX = 1'b0; branch_taken_EX = 1'b0;
   endtask

   // Called with inputs already driven after a negedge; checks, advances model, waits next negedge.
   task automatic cyc(input string tag);
      logic [6:0] e, o;
      #1;
      e = model_out();
      o = {stall_IF, stall_ID, stall_EX, flush_ID, flush_EX, flush_MEM, md_busy};
      total++;
      assert (o === e) passed++;
      else $error("FAIL %s: outputs=%b expected=%b", tag, o, e);
`ifdef HAZARD_PERF_EN
      total++;
      assert (stall_count === 32'(m_stalls)) passed++;
      else $error("FAIL %s_stall_count: got=%0d expected=%0d", tag, stall_count, m_stalls);
      total++;
      assert (flush_count === 32'(m_flushes)) passed++;
      else $error("FAIL %s_flush_count: got=%0d expected=%0d", tag, flush_count, m_flushes);
`endif
      model_step(e);
      @(negedge clk);
   endtask

   initial begin
`ifdef HAZARD_PERF_EN
      m_stalls = 0;
      m_flushes = 0;
`endif
      idle();
      rst = 1'b1;
      @(negedge clk);
      cyc("reset");
      md_start_EX = 1'b1; mem_read_EX = 1'b1; branch_taken_EX = 1'b1;
      cyc("reset_inputs_ignored");
      idle();
      rst = 1'b0;
      cyc("idle");

      // Load-use on rs, then load gone
      mem_read_EX = 1'b1; rt_num_EX = 5'd5; rs_num_ID = 5'd5; uses_rs_ID = 1'b1;
      cyc("load_use_rs");
      mem_read_EX = 1'b0;
      cyc("load_use_after");
      // Load-use on rt
      mem_read_EX = 1'b1; uses_rs_ID = 1'b0; rs_num_ID = 5'd1; rt_num_ID = 5'd5; uses_rt_ID = 1'b1;
      cyc("load_use_rt");
      // rt match but operand unused
      uses_rt_ID = 1'b0;
      cyc("rt_unused");
      // $zero immunity
      idle();
      mem_read_EX = 1'b1; uses_rs_ID = 1'b1;
      cyc("zero_reg");
      idle();

      // Mult/div held L cycles, then a new mult/div proves RUN
      md_start_EX = 1'b1;
      for (int i = 0; i < L; i++) cyc($sformatf("md_T%0d", i));
      cyc("md_restart");
      md_start_EX = 1'b0;
      // Branch during MD_WAIT is ignored
      branch_taken_EX = 1'b1;
      mem_read_EX = 1'b1; rt_num_EX = 5'd7; rs_num_ID = 5'd7; uses_rs_ID = 1'b1;
      cyc("md_wait_branch");
      cyc("md_wait_branch2");
      // Release cycle: branch + load-use -> branch wins
      cyc("release_branch_prio");
      cyc("branch_prio");
      branch_taken_EX = 1'b0;
      cyc("load_use_again");
      idle();

      // Reset mid mult/div
      md_start_EX = 1'b1;
      cyc("md_pre_reset");
      rst = 1'b1;
      cyc("md_reset1");
      cyc("md_reset2");
      rst = 1'b0; md_start_EX = 1'b0;
      cyc("post_reset");
      cyc("post_reset2");

      // Randomized traffic
      for (int n = 0; n < 600; n++) begin
         rst             = ($urandom_range(0, 49) == 0);
         rs_num_ID       = 5'($urandom_range(0, 3));
         rt_num_ID       = 5'($urandom_range(0, 3));
         rt_num_EX       = 5'($urandom_range(0, 3));
         uses_rs_ID      = 1'($urandom);
         uses_rt_ID      = 1'($urandom);
         mem_read_EX     = 1'($urandom);
         md_start_EX     = ($urandom_range(0, 4) == 0);
         branch_taken_EX = ($urandom_range(0, 5) == 0);
         cyc("random");
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, elapsed=%0t limit=100000", $time);
      $fatal(1, "timeout");
   end

endmodule
